// File: rtl/fiber_bus_master_pkg.sv
// Shared types and constants for the fiber register-bus initiator.
// FSM encoding, timeout response pattern and default timing knobs.
package fiber_bus_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_RESP   = 3'd3,
        ST_GAP    = 3'd4
    } fbm_state_t;

    localparam logic [31:0] FBM_TMO_DATA  = 32'hFFFF_FFFF;
    localparam int          FBM_TIMEOUT   = 255;
    localparam int          FBM_GAP       = 2;
    localparam int          FBM_ADDR_STEP = 4;

endpackage

// File: rtl/fiber_bus_master.sv
// Fiber register-bus initiator: single writes and burst reads, accept-to-response 5 cycles with a 2-cycle ACK.
// Responses hold until RSP_READY; no new strobe is issued while a response is pending.
module fiber_bus_master
    import fiber_bus_master_pkg::*;
#(
    parameter int TIMEOUT   = FBM_TIMEOUT,
    parameter int GAP       = FBM_GAP,
    parameter int ADDR_STEP = FBM_ADDR_STEP
) (
    input  logic        CLK,
    input  logic        RSTb,
    input  logic        ENABLE,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WR,
    input  logic [31:0] CMD_ADDR,
    input  logic [31:0] CMD_DATA,
    input  logic [7:0]  CMD_LEN,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [31:0] RSP_DATA,
    output logic        RSP_ERR,
    output logic        RSP_LAST,
    output logic [31:0] FIBER_BUS_ADDR,
    output logic [31:0] FIBER_BUS_DOUT,
    input  logic [31:0] FIBER_BUS_DIN,
    output logic        FIBER_BUS_WR,
    output logic        FIBER_BUS_RD,
    input  logic        FIBER_BUS_ACK,
    output logic        BUSY
);

    fbm_state_t  state;
    logic        is_wr;
    logic [7:0]  remaining;
    logic [15:0] tmo_cnt;
    logic [7:0]  gap_cnt;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state          <= ST_IDLE;
            is_wr          <= 1'b0;
            remaining      <= '0;
            tmo_cnt        <= '0;
            gap_cnt        <= '0;
            CMD_READY      <= 1'b0;
            RSP_VALID      <= 1'b0;
            RSP_DATA       <= '0;
            RSP_ERR        <= 1'b0;
            RSP_LAST       <= 1'b0;
            FIBER_BUS_ADDR <= '0;
            FIBER_BUS_DOUT <= '0;
            FIBER_BUS_WR   <= 1'b0;
            FIBER_BUS_RD   <= 1'b0;
            BUSY           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    CMD_READY <= ENABLE;
                    if (CMD_VALID && CMD_READY) begin
                        is_wr          <= CMD_WR;
                        FIBER_BUS_ADDR <= CMD_ADDR;
                        FIBER_BUS_DOUT <= CMD_WR ? CMD_DATA : 32'h0;
                        remaining      <= CMD_WR ? 8'h0 : CMD_LEN;
                        CMD_READY      <= 1'b0;
                        BUSY           <= 1'b1;
                        state          <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    tmo_cnt      <= '0;
                    FIBER_BUS_WR <= is_wr;
                    FIBER_BUS_RD <= !is_wr;
                    state        <= ST_STROBE;
                end
                ST_STROBE: begin
                    // ACK wins over a timeout landing on the same cycle
                    if (FIBER_BUS_ACK) begin
                        FIBER_BUS_WR <= 1'b0;
                        FIBER_BUS_RD <= 1'b0;
                        RSP_DATA     <= is_wr ? 32'h0 : FIBER_BUS_DIN;
                        RSP_ERR      <= 1'b0;
                        RSP_LAST     <= (remaining == 8'h0);
                        RSP_VALID    <= 1'b1;
                        state        <= ST_RESP;
                    end else if (tmo_cnt == 16'(TIMEOUT - 1)) begin
                        FIBER_BUS_WR <= 1'b0;
                        FIBER_BUS_RD <= 1'b0;
                        RSP_DATA     <= FBM_TMO_DATA;
                        RSP_ERR      <= 1'b1;
                        RSP_LAST     <= 1'b1;
                        RSP_VALID    <= 1'b1;
                        state        <= ST_RESP;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'h1;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        gap_cnt   <= '0;
                        if (!RSP_LAST) begin
                            remaining      <= remaining - 8'h1;
                            FIBER_BUS_ADDR <= FIBER_BUS_ADDR + 32'(ADDR_STEP);
                        end
                        state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // strobes stay low here so the responder always sees a fresh rising edge
                    if (gap_cnt == 8'(GAP - 1)) begin
                        if (RSP_LAST) begin
                            CMD_READY <= ENABLE;
                            BUSY      <= 1'b0;
                            state     <= ST_IDLE;
                        end else begin
                            state <= ST_SETUP;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 8'h1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
